// File: rtl/edge_sobel_pipe.sv
// edge_sobel_pipe: three-stage 3x3 Sobel edge operator with per-frame shadowed
// mode/threshold, delay-matched sync outputs and a per-frame edge-pixel counter.
module edge_sobel_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 20
) (
    input  logic                  pclk_i,
    input  logic                  rst_i,
    input  logic                  fsync_i,
    input  logic                  rsync_i,
    input  logic [DATA_WIDTH-1:0] pData1,
    input  logic [DATA_WIDTH-1:0] pData2,
    input  logic [DATA_WIDTH-1:0] pData3,
    input  logic [DATA_WIDTH-1:0] pData4,
    input  logic [DATA_WIDTH-1:0] pData5,
    input  logic [DATA_WIDTH-1:0] pData6,
    input  logic [DATA_WIDTH-1:0] pData7,
    input  logic [DATA_WIDTH-1:0] pData8,
    input  logic [DATA_WIDTH-1:0] pData9,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] thresh_i,
    output logic                  fsync_o,
    output logic                  rsync_o,
    output logic [DATA_WIDTH-1:0] pdata_o,
    output logic [CNT_W-1:0]      edge_cnt_o,
    output logic                  cnt_valid_o
);

    localparam int GW = DATA_WIDTH + 3;
    localparam int AW = DATA_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;
    localparam logic [DATA_WIDTH-1:0] THR_RST = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        MODE_MAG  = 2'd0,
        MODE_BIN  = 2'd1,
        MODE_CLIP = 2'd2,
        MODE_GX   = 2'd3
    } mode_e;

    // Pixel zero-extended into the signed gradient width.
    function automatic logic signed [GW-1:0] widen(input logic [DATA_WIDTH-1:0] p);
        return $signed({3'b000, p});
    endfunction

    logic                  fs_rise;
    logic                  fsync_prev_d, fsync_prev_q;
    mode_e                 mode_s_d, mode_s_q;
    logic [DATA_WIDTH-1:0] thr_s_d, thr_s_q;

    logic                  s1_valid_d, s1_valid_q;
    logic                  s1_fsync_d, s1_fsync_q;
    logic                  s1_rsync_d, s1_rsync_q;
    mode_e                 s1_mode_d, s1_mode_q;
    logic [DATA_WIDTH-1:0] s1_thr_d, s1_thr_q;
    logic signed [GW-1:0]  s1_gx_d, s1_gx_q;
    logic signed [GW-1:0]  s1_gy_d, s1_gy_q;

    logic                  s2_valid_d, s2_valid_q;
    logic                  s2_fsync_d, s2_fsync_q;
    logic                  s2_rsync_d, s2_rsync_q;
    mode_e                 s2_mode_d, s2_mode_q;
    logic [DATA_WIDTH-1:0] s2_thr_d, s2_thr_q;
    logic [AW-1:0]         s2_ax_d, s2_ax_q;
    logic [AW-1:0]         ay_abs;
    logic [GW-1:0]         s2_mag_d, s2_mag_q;

    logic                  s3_fsync_d, s3_fsync_q;
    logic                  s3_rsync_d, s3_rsync_q;
    logic [DATA_WIDTH-1:0] pdata_d, pdata_q;
    logic [GW-1:0]         thr_ext;
    logic                  is_edge;
    logic [DATA_WIDTH-1:0] mag_sat;
    logic [DATA_WIDTH-1:0] ax_sat;
    logic                  frame_end;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic [CNT_W-1:0]      edge_cnt_d, edge_cnt_q;
    logic                  cnt_valid_d, cnt_valid_q;

    // Frame-start shadow capture; the capturing pixel already uses the new values.
    always_comb begin
        fs_rise      = fsync_i && !fsync_prev_q;
        fsync_prev_d = fsync_i;
        mode_s_d     = mode_s_q;
        thr_s_d      = thr_s_q;
        if (fs_rise) begin
            mode_s_d = mode_e'(mode_i);
            thr_s_d  = thresh_i;
        end
        s1_valid_d = fsync_i && rsync_i;
        s1_fsync_d = fsync_i;
        s1_rsync_d = rsync_i;
        s1_mode_d  = mode_s_d;
        s1_thr_d   = thr_s_d;
        s1_gx_d    = (widen(pData3) + (widen(pData6) <<< 1) + widen(pData9))
                   - (widen(pData1) + (widen(pData4) <<< 1) + widen(pData7));
        s1_gy_d    = (widen(pData7) + (widen(pData8) <<< 1) + widen(pData9))
                   - (widen(pData1) + (widen(pData2) <<< 1) + widen(pData3));
    end

    // Stage 2: absolute gradients and their sum (largest value 8*MAX fits GW bits).
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_fsync_d = s1_fsync_q;
        s2_rsync_d = s1_rsync_q;
        s2_mode_d  = s1_mode_q;
        s2_thr_d   = s1_thr_q;
        s2_ax_d    = s1_gx_q[GW-1] ? AW'(-s1_gx_q) : AW'(s1_gx_q);
        ay_abs     = s1_gy_q[GW-1] ? AW'(-s1_gy_q) : AW'(s1_gy_q);
        s2_mag_d   = {1'b0, s2_ax_d} + {1'b0, ay_abs};
    end

    // Stage 3 output select plus the counter, which snapshots one cycle ahead of
    // the visible fsync_o fall so the pulse and the new count appear together.
    always_comb begin
        thr_ext    = {3'b000, s2_thr_q};
        is_edge    = s2_valid_q && (s2_mag_q > thr_ext);
        mag_sat    = (s2_mag_q > {3'b000, PIX_MAX}) ? PIX_MAX : s2_mag_q[DATA_WIDTH-1:0];
        ax_sat     = (s2_ax_q > {2'b00, PIX_MAX}) ? PIX_MAX : s2_ax_q[DATA_WIDTH-1:0];
        pdata_d    = '0;
        if (s2_valid_q) begin
            case (s2_mode_q)
                MODE_MAG:  pdata_d = mag_sat;
                MODE_BIN:  pdata_d = is_edge ? PIX_MAX : '0;
                MODE_CLIP: pdata_d = is_edge ? PIX_MAX : s2_mag_q[DATA_WIDTH-1:0];
                MODE_GX:   pdata_d = ax_sat;
                default:   pdata_d = '0;
            endcase
        end
        s3_fsync_d  = s2_fsync_q;
        s3_rsync_d  = s2_rsync_q;
        frame_end   = s3_fsync_q && !s2_fsync_q;
        cnt_valid_d = frame_end;
        edge_cnt_d  = frame_end ? cnt_q : edge_cnt_q;
        cnt_d       = cnt_q;
        if (frame_end) begin
            cnt_d = '0;
        end else if (is_edge && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // All state; fsync_prev resets high so a frame already running at release is not treated as a start.
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            fsync_prev_q <= 1'b1;
            mode_s_q     <= MODE_CLIP;
            thr_s_q      <= THR_RST;
            s1_valid_q   <= 1'b0;
            s1_fsync_q   <= 1'b0;
            s1_rsync_q   <= 1'b0;
            s1_mode_q    <= MODE_CLIP;
            s1_thr_q     <= THR_RST;
            s1_gx_q      <= '0;
            s1_gy_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_fsync_q   <= 1'b0;
            s2_rsync_q   <= 1'b0;
            s2_mode_q    <= MODE_CLIP;
            s2_thr_q     <= THR_RST;
            s2_ax_q      <= '0;
            s2_mag_q     <= '0;
            s3_fsync_q   <= 1'b0;
            s3_rsync_q   <= 1'b0;
            pdata_q      <= '0;
            cnt_q        <= '0;
            edge_cnt_q   <= '0;
            cnt_valid_q  <= 1'b0;
        end else begin
            fsync_prev_q <= fsync_prev_d;
            mode_s_q     <= mode_s_d;
            thr_s_q      <= thr_s_d;
            s1_valid_q   <= s1_valid_d;
            s1_fsync_q   <= s1_fsync_d;
            s1_rsync_q   <= s1_rsync_d;
            s1_mode_q    <= s1_mode_d;
            s1_thr_q     <= s1_thr_d;
            s1_gx_q      <= s1_gx_d;
            s1_gy_q      <= s1_gy_d;
            s2_valid_q   <= s2_valid_d;
            s2_fsync_q   <= s2_fsync_d;
            s2_rsync_q   <= s2_rsync_d;
            s2_mode_q    <= s2_mode_d;
            s2_thr_q     <= s2_thr_d;
            s2_ax_q      <= s2_ax_d;
            s2_mag_q     <= s2_mag_d;
            s3_fsync_q   <= s3_fsync_d;
            s3_rsync_q   <= s3_rsync_d;
            pdata_q      <= pdata_d;
            cnt_q        <= cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            cnt_valid_q  <= cnt_valid_d;
        end
    end

    assign fsync_o     = s3_fsync_q;
    assign rsync_o     = s3_rsync_q;
    assign pdata_o     = pdata_q;
    assign edge_cnt_o  = edge_cnt_q;
    assign cnt_valid_o = cnt_valid_q;

endmodule

// File: tb/tb_edge_sobel_pipe.sv
// tb_edge_sobel_pipe: directed scoreboard bench for edge_sobel_pipe.
module tb_edge_sobel_pipe;

    localparam int DW = 8;
    localparam int CW = 20;

    logic          pclk_i = 1'b0;
    logic          rst_i;
    logic          fsync_i;
    logic          rsync_i;
    logic [DW-1:0] pData1, pData2, pData3, pData4, pData5, pData6, pData7, pData8, pData9;
    logic [1:0]    mode_i;
    logic [DW-1:0] thresh_i;
    logic          fsync_o;
    logic          rsync_o;
    logic [DW-1:0] pdata_o;
    logic [CW-1:0] edge_cnt_o;
    logic          cnt_valid_o;

    typedef struct {
        logic [DW-1:0] pdata;
        logic          fs;
        logic          rs;
        logic          cv;
        logic [CW-1:0] ecnt;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] pat [1:9];
    int            vectors = 0;
    int            miscompares = 0;

    // reference state: shadow registers, previous fsync_i, stream fsync history, counters
    logic          m_fprev;
    logic [1:0]    m_mode;
    logic [DW-1:0] m_thr;
    logic          m_sprev;
    int            m_cnt;
    int            m_ecnt;

    edge_sobel_pipe #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .pclk_i(pclk_i), .rst_i(rst_i), .fsync_i(fsync_i), .rsync_i(rsync_i),
        .pData1(pData1), .pData2(pData2), .pData3(pData3),
        .pData4(pData4), .pData5(pData5), .pData6(pData6),
        .pData7(pData7), .pData8(pData8), .pData9(pData9),
        .mode_i(mode_i), .thresh_i(thresh_i),
        .fsync_o(fsync_o), .rsync_o(rsync_o), .pdata_o(pdata_o),
        .edge_cnt_o(edge_cnt_o), .cnt_valid_o(cnt_valid_o)
    );

    // free-running pixel clock
    always #5 pclk_i = ~pclk_i;

    // hard stop in case the sequence ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic popAndCheck();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard: observed empty queue expected a pending entry");
        end else begin
            e = sb.pop_front();
            checkOutput("pdata",     32'(pdata_o),     32'(e.pdata));
            checkOutput("fsync",     32'(fsync_o),     32'(e.fs));
            checkOutput("rsync",     32'(rsync_o),     32'(e.rs));
            checkOutput("cnt_valid", 32'(cnt_valid_o), 32'(e.cv));
            checkOutput("edge_cnt",  32'(edge_cnt_o),  32'(e.ecnt));
        end
    endtask

    // 0 zero, 1 flat 100, 2 strong vertical, 3 weak right column, 4 weak left column, 5 bottom row, 6 random
    task automatic loadPat(input int kind);
        for (int i = 1; i <= 9; i++) begin
            case (kind)
                1:       pat[i] = 8'd100;
                6:       pat[i] = 8'($urandom_range(0, 255));
                default: pat[i] = 8'd0;
            endcase
        end
        case (kind)
            2: begin pat[3] = 8'd255; pat[6] = 8'd255; pat[9] = 8'd255; end
            3: begin pat[3] = 8'd10;  pat[6] = 8'd10;  pat[9] = 8'd10;  end
            4: begin pat[1] = 8'd10;  pat[4] = 8'd10;  pat[7] = 8'd10;  end
            5: begin pat[7] = 8'd200; pat[8] = 8'd200; pat[9] = 8'd200; end
            default: ;
        endcase
    endtask

    function automatic logic [DW-1:0] modelPix(input logic [1:0] md, input logic [DW-1:0] th,
                                                output logic isEdge);
        int q [1:9];
        int gx, gy, ax, ay, mag, r;
        for (int i = 1; i <= 9; i++) q[i] = int'(pat[i]);
        gx  = (q[3] + 2 * q[6] + q[9]) - (q[1] + 2 * q[4] + q[7]);
        gy  = (q[7] + 2 * q[8] + q[9]) - (q[1] + 2 * q[2] + q[3]);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = ax + ay;
        isEdge = (mag > int'(th));
        case (md)
            2'd0:    r = (mag > 255) ? 255 : mag;
            2'd1:    r = isEdge ? 255 : 0;
            2'd2:    r = isEdge ? 255 : (mag % 256);
            default: r = (ax > 255) ? 255 : ax;
        endcase
        return 8'(r);
    endfunction

    task automatic applyStimulus(input int kind, input logic fs, input logic rs);
        exp_t e;
        logic edgeFlag;
        logic [DW-1:0] px;
        loadPat(kind);
        fsync_i = fs;
        rsync_i = rs;
        pData1 = pat[1]; pData2 = pat[2]; pData3 = pat[3];
        pData4 = pat[4]; pData5 = pat[5]; pData6 = pat[6];
        pData7 = pat[7]; pData8 = pat[8]; pData9 = pat[9];
        if (fs && !m_fprev) begin
            m_mode = mode_i;
            m_thr  = thresh_i;
        end
        m_fprev = fs;
        px = modelPix(m_mode, m_thr, edgeFlag);
        e.cv = m_sprev && !fs;
        if (e.cv) begin
            m_ecnt = m_cnt;
            m_cnt  = 0;
        end
        m_sprev = fs;
        if (fs && rs && edgeFlag) m_cnt++;
        e.pdata = (fs && rs) ? px : '0;
        e.fs    = fs;
        e.rs    = rs;
        e.ecnt  = CW'(m_ecnt);
        sb.push_back(e);
        @(posedge pclk_i);
        #1;
        popAndCheck();
    endtask

    task automatic applyReset();
        exp_t z;
        z.pdata = '0; z.fs = 1'b0; z.rs = 1'b0; z.cv = 1'b0; z.ecnt = '0;
        rst_i = 1'b1;
        sb.delete();
        sb.push_back(z);
        m_fprev = 1'b1;
        m_mode  = 2'd2;
        m_thr   = 8'd127;
        m_sprev = 1'b0;
        m_cnt   = 0;
        m_ecnt  = 0;
        @(posedge pclk_i);
        #1;
        rst_i = 1'b0;
        popAndCheck();
        sb.push_back(z);
        sb.push_back(z);
    endtask

    // directed sequence
    initial begin
        rst_i = 1'b1; fsync_i = 1'b0; rsync_i = 1'b0; mode_i = 2'd0; thresh_i = 8'd0;
        pData1 = '0; pData2 = '0; pData3 = '0; pData4 = '0; pData5 = '0;
        pData6 = '0; pData7 = '0; pData8 = '0; pData9 = '0;
        applyReset();
        applyReset();
        for (int i = 0; i < 2; i++) applyStimulus(0, 1'b0, 1'b0);

        // mode 0 (magnitude) with row gap and random windows
        mode_i = 2'd0; thresh_i = 8'd127;
        applyStimulus(2, 1'b1, 1'b1);
        applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(4, 1'b1, 1'b1);
        applyStimulus(5, 1'b1, 1'b1);
        applyStimulus(1, 1'b1, 1'b1);
        applyStimulus(2, 1'b1, 1'b0);
        applyStimulus(2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(6, 1'b1, 1'b1);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);

        // mode 1 (binary) thr 100
        mode_i = 2'd1; thresh_i = 8'd100;
        applyStimulus(2, 1'b1, 1'b1);
        applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(5, 1'b1, 1'b1);
        applyStimulus(1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(6, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);

        // mode 3 (gx only)
        mode_i = 2'd3; thresh_i = 8'd100;
        applyStimulus(2, 1'b1, 1'b1);
        applyStimulus(4, 1'b1, 1'b1);
        applyStimulus(5, 1'b1, 1'b1);
        applyStimulus(1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(6, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);

        // mode 2 (clip) thr 127
        mode_i = 2'd2; thresh_i = 8'd127;
        applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(2, 1'b1, 1'b1);
        applyStimulus(1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(6, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);

        // strict threshold: mag 40 against thr 30 then thr 40
        mode_i = 2'd1; thresh_i = 8'd30;
        applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);
        thresh_i = 8'd40;
        applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);

        // frame A: mid-frame mode/threshold changes must not take effect
        mode_i = 2'd1; thresh_i = 8'd30;
        for (int i = 0; i < 3; i++) applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(1, 1'b1, 1'b1);
        thresh_i = 8'd50; mode_i = 2'd0;
        for (int i = 0; i < 4; i++) applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(3, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b1);
        mode_i = 2'd1;
        applyStimulus(0, 1'b0, 1'b0);

        // frame B back-to-back after a single-cycle gap, picks up thr 50
        for (int i = 0; i < 3; i++) applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(3, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 1'b0);

        // reset in the middle of a frame, then the remainder, then a full frame
        mode_i = 2'd1; thresh_i = 8'd30;
        for (int i = 0; i < 3; i++) applyStimulus(3, 1'b1, 1'b1);
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(3, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(3, 1'b1, 1'b1);
        applyStimulus(1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
